// File: rtl/mapctx_pkg.sv
// Shared types for the mapper context sequencer: FSM encodings, map register selects, context word.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package mapctx_pkg;

   // FSM state encodings
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SAVE  = 3'd1;
   localparam state_t ST_PUSH  = 3'd2;
   localparam state_t ST_RWAIT = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_BWAIT = 3'd5;
   localparam state_t ST_DONE  = 3'd6;

   // Map register selects as seen by the mapper
   localparam logic [1:0] SEL_A = 2'd3;
   localparam logic [1:0] SEL_X = 2'd2;
   localparam logic [1:0] SEL_Y = 2'd1;
   localparam logic [1:0] SEL_Z = 2'd0;

   // Saved context: A in the top byte down to Z in the bottom byte
   typedef logic [31:0] ctx_word_t;
   localparam int OFS_A = 24;
   localparam int OFS_X = 16;
   localparam int OFS_Y = 8;
   localparam int OFS_Z = 0;

   function automatic logic [7:0] ctx_get(input ctx_word_t w, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         SEL_A:   b = w[OFS_A +: 8];
         SEL_X:   b = w[OFS_X +: 8];
         SEL_Y:   b = w[OFS_Y +: 8];
         default: b = w[OFS_Z +: 8];
      endcase
      return b;
   endfunction

   function automatic ctx_word_t ctx_set(input ctx_word_t w, input logic [1:0] sel, input logic [7:0] b);
      ctx_word_t r;
      r = w;
      case (sel)
         SEL_A:   r[OFS_A +: 8] = b;
         SEL_X:   r[OFS_X +: 8] = b;
         SEL_Y:   r[OFS_Y +: 8] = b;
         default: r[OFS_Z +: 8] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mapper_ctx_sequencer_if.sv
// Trap-controller and mapper signal bundle for the context sequencer; host write path only with MAPCTX_HOST_WRITE_EN.
// Latency: n/a (wiring only).
// Backpressure: level requests held until the matching done pulse; host_ready qualifies host writes.
interface mapper_ctx_sequencer_if;
   logic       save_req;
   logic       restore_req;
   logic       save_done;
   logic       restore_done;
   logic [1:0] reg_sel;
   logic       seq_active;
   logic [7:0] map_reg_data;
   logic       map;
   logic       mapper_busy;
   logic       hypervisor_load_user_reg;
   logic [1:0] map_reg_write_sel;
   logic [7:0] wr_data;
`ifdef MAPCTX_HOST_WRITE_EN
   logic       host_wr;
   logic [1:0] host_sel;
   logic [7:0] host_data;
   logic       host_ready;

   modport master (
      input  save_req, restore_req, map_reg_data, map, mapper_busy, host_wr, host_sel, host_data,
      output save_done, restore_done, reg_sel, seq_active, hypervisor_load_user_reg,
             map_reg_write_sel, wr_data, host_ready
   );
   modport slave (
      output save_req, restore_req, map_reg_data, map, mapper_busy, host_wr, host_sel, host_data,
      input  save_done, restore_done, reg_sel, seq_active, hypervisor_load_user_reg,
             map_reg_write_sel, wr_data, host_ready
   );
`else
   modport master (
      input  save_req, restore_req, map_reg_data, map, mapper_busy,
      output save_done, restore_done, reg_sel, seq_active, hypervisor_load_user_reg,
             map_reg_write_sel, wr_data
   );
   modport slave (
      output save_req, restore_req, map_reg_data, map, mapper_busy,
      input  save_done, restore_done, reg_sel, seq_active, hypervisor_load_user_reg,
             map_reg_write_sel, wr_data
   );
`endif
endinterface

// File: rtl/mapctx_lifo.sv
// DEPTH x W synchronous stack; top of stack is readable combinationally.
// Latency: push/pop take effect at the next clock edge.
// Backpressure: none; caller must respect o_full/o_empty (index wraps modulo DEPTH).
module mapctx_lifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_dat,
   output logic [W-1:0]             o_top,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_m1;

   assign w_cnt_m1 = r_cnt - 1'b1;
   assign o_top    = r_mem[w_cnt_m1[AW-1:0]];
   assign o_full   = (r_cnt == CW'(DEPTH));
   assign o_empty  = (r_cnt == '0);
   assign o_count  = r_cnt;

   // occupancy counter doubles as the stack pointer
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_push && !i_pop) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_pop && !i_push) begin
         r_cnt <= w_cnt_m1;
      end
   end

   // storage write at the current pointer; contents need no reset
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_cnt[AW-1:0]] <= i_dat;
      end
   end
endmodule

// File: rtl/mapper_ctx_sequencer.sv
// Saves/restores the user mapper A/X/Y/Z registers around hypervisor traps on a LIFO; MAPCTX_HOST_WRITE_EN adds a host write path.
// Latency: save 6 cycles to save_done; restore = map wait + 4 writes (+ map stalls) + busy wait + 1.
// Backpressure: requests held until done; writes stall while map is high; host writes accepted only when idle and map low.
module mapper_ctx_sequencer
   import mapctx_pkg::*;
#(
   parameter int CTX_DEPTH    = 4,
   parameter int BUSY_TIMEOUT = 32
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_err_clr,
   output logic                        o_err_overflow,
   output logic                        o_err_underflow,
   output logic                        o_err_timeout,
   output logic [$clog2(CTX_DEPTH):0]  o_depth,
   mapper_ctx_sequencer_if.master      bus
);
   localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

   state_t      r_state;
   logic [1:0]  r_step;
   logic [TW-1:0] r_tmr;
   ctx_word_t   r_word;
   logic        r_is_rst;
   logic        r_save_blk;
   logic        r_rest_blk;
   logic        r_err_ovf;
   logic        r_err_unf;
   logic        r_err_tmo;

   logic        w_full;
   logic        w_empty;
   ctx_word_t   w_top;
   logic        w_push;
   logic        w_pop;
   logic [1:0]  w_sel;
   logic        w_seq_wr;
   logic        w_host_go;

   // registers are walked A, X, Y, Z as the step counter advances
   assign w_sel    = SEL_A - r_step;
   assign w_seq_wr = (r_state == ST_WRITE) && !bus.map;
   assign w_push   = (r_state == ST_PUSH);
   assign w_pop    = w_seq_wr && (r_step == 2'd3);

`ifdef MAPCTX_HOST_WRITE_EN
   assign w_host_go = !i_reset && (r_state == ST_IDLE) && !bus.map && bus.host_wr;
`else
   assign w_host_go = 1'b0;
`endif

   mapctx_lifo #(
      .DEPTH (CTX_DEPTH),
      .W     ($bits(ctx_word_t))
   ) u_lifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_dat   (r_word),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_depth)
   );

   // sequencer FSM, sticky error flags and request edge qualification
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_step     <= 2'd0;
         r_tmr      <= '0;
         r_word     <= '0;
         r_is_rst   <= 1'b0;
         r_save_blk <= 1'b0;
         r_rest_blk <= 1'b0;
         r_err_ovf  <= 1'b0;
         r_err_unf  <= 1'b0;
         r_err_tmo  <= 1'b0;
      end else begin
         // clear first so a same-cycle error set below takes priority
         if (i_err_clr) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_tmo <= 1'b0;
         end
         if (!bus.save_req)    r_save_blk <= 1'b0;
         if (!bus.restore_req) r_rest_blk <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_step <= 2'd0;
               r_tmr  <= '0;
               if (w_host_go) begin
                  // host owns the write path this cycle; requests wait one cycle
               end else if (bus.save_req) begin
                  if (!r_save_blk) begin
                     r_is_rst <= 1'b0;
                     if (w_full) begin
                        r_err_ovf <= 1'b1;
                        r_state   <= ST_DONE;
                     end else begin
                        r_state   <= ST_SAVE;
                     end
                  end
               end else if (bus.restore_req && !r_rest_blk) begin
                  r_is_rst <= 1'b1;
                  if (w_empty) begin
                     r_err_unf <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     r_state   <= ST_RWAIT;
                  end
               end
            end
            ST_SAVE: begin
               r_word <= ctx_set(r_word, w_sel, bus.map_reg_data);
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) r_state <= ST_PUSH;
            end
            ST_PUSH: begin
               r_state <= ST_DONE;
            end
            ST_RWAIT: begin
               if (!bus.map) begin
                  r_word  <= w_top;
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // a map stall holds the step so the same register is retried
               if (!bus.map) begin
                  r_step <= r_step + 2'd1;
                  if (r_step == 2'd3) r_state <= ST_BWAIT;
               end
            end
            ST_BWAIT: begin
               if (!bus.mapper_busy) begin
                  r_state <= ST_DONE;
               end else if (r_tmr == TW'(BUSY_TIMEOUT - 1)) begin
                  r_err_tmo <= 1'b1;
                  r_state   <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            ST_DONE: begin
               // a request still asserted must be seen low before it is serviced again
               if (r_is_rst) r_rest_blk <= bus.restore_req;
               else          r_save_blk <= bus.save_req;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_err_overflow  = r_err_ovf;
   assign o_err_underflow = r_err_unf;
   assign o_err_timeout   = r_err_tmo;

   // status, readback select and done pulses decoded from state
   always_comb begin
      bus.seq_active   = (r_state != ST_IDLE);
      bus.reg_sel      = (r_state == ST_SAVE) ? w_sel : SEL_A;
      bus.save_done    = (r_state == ST_DONE) && !r_is_rst;
      bus.restore_done = (r_state == ST_DONE) &&  r_is_rst;
   end

   // mapper write port: sequencer restore, or host pass-through when idle
   always_comb begin
      bus.hypervisor_load_user_reg = w_seq_wr;
      bus.map_reg_write_sel        = w_seq_wr ? w_sel : 2'd0;
      bus.wr_data                  = w_seq_wr ? ctx_get(r_word, w_sel) : 8'd0;
`ifdef MAPCTX_HOST_WRITE_EN
      bus.host_ready = w_host_go;
      if (w_host_go) begin
         bus.hypervisor_load_user_reg = 1'b1;
         bus.map_reg_write_sel        = bus.host_sel;
         bus.wr_data                  = bus.host_data;
      end
`endif
   end
endmodule
